// File: rtl/cam_pkg.sv
// Shared encodings and frame geometry for the OV7670 capture controller.
package cam_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_SNAP  = 1'b0,
        MODE_VIDEO = 1'b1
    } mode_t;

    localparam int FRAME_W       = 160;
    localparam int FRAME_H       = 120;
    localparam int CAM_MEM_DEPTH = FRAME_W * FRAME_H;

    localparam logic [2:0] LED_FRAMES = 3'd1;
    localparam logic [2:0] LED_LINES  = 3'd2;
    localparam logic [2:0] LED_PIXELS = 3'd3;
    localparam logic [2:0] LED_LPX    = 3'd4;
    localparam logic [2:0] LED_STATUS = 3'd7;
endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera timing / pixel-writer handshake between the capture controller and the writer.
interface cam_capture_ctrl_if;
    logic vsync;
    logic href;
    logic px_wr_in;
    logic cap_en;
    logic frame_start;
    logic frame_done;

    modport master (input vsync, href, px_wr_in, output cap_en, frame_start, frame_done);
    modport slave  (output vsync, href, px_wr_in, input cap_en, frame_start, frame_done);
endinterface

// File: rtl/cam_btn_sync.sv
// Two-flop synchronizer plus rising-edge detect: one-cycle press pulse per button press.
module cam_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_press = r_sync & ~r_prev;
endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame capture sequencer: snapshot / continuous / decimated video, pixel and frame counters.
// Optional line statistics on the debug leds when CAM_CTRL_LINE_STATS_EN is defined.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int AW        = 15,
    parameter int MEM_DEPTH = CAM_MEM_DEPTH,
    parameter int SKIP_W    = 3
) (
    input  logic              pclk,
    input  logic              rst,
    cam_capture_ctrl_if.master cam,
    input  logic              btn_snap,
    input  logic              btn_video,
    input  logic              btn_stop,
    input  logic [SKIP_W-1:0] skip_n,
    input  logic [2:0]        option,
    output logic [1:0]        state_o,
    output logic [7:0]        frame_cnt,
    output logic              overflow,
    output logic [15:0]       leds
);
    localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

    logic w_snap_p, w_video_p, w_stop_p;
    logic w_snap, w_video, w_stop;
    logic r_vs_q, w_vs_fall, w_vs_rise;

    state_t            r_state, w_state_nxt;
    mode_t             r_mode, w_mode_nxt;
    logic [SKIP_W-1:0] r_skip_cnt, w_skip_nxt;
    logic              w_start_nxt, w_done_nxt, w_arm_entry;

    logic              r_cap_en, r_frame_start, r_frame_done;
    logic [7:0]        r_frame_cnt;
    logic [AW-1:0]     r_px_cnt;
    logic              r_overflow;
    logic [15:0]       r_leds;

    cam_btn_sync u_sync_snap  (.clk(pclk), .rst(rst), .i_btn(btn_snap),  .o_press(w_snap_p));
    cam_btn_sync u_sync_video (.clk(pclk), .rst(rst), .i_btn(btn_video), .o_press(w_video_p));
    cam_btn_sync u_sync_stop  (.clk(pclk), .rst(rst), .i_btn(btn_stop),  .o_press(w_stop_p));

    assign w_stop  = w_stop_p;
    assign w_snap  = w_snap_p & ~w_stop_p;
    assign w_video = w_video_p & ~w_stop_p & ~w_snap_p;

    assign w_vs_fall = r_vs_q & ~cam.vsync;
    assign w_vs_rise = ~r_vs_q & cam.vsync;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SNAP;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_skip_nxt  = r_skip_cnt;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_FROZEN: begin
                // Every fresh arm starts with no pending skips, even after a stopped video run.
                if (r_state == ST_FROZEN && w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_snap) begin
                    w_mode_nxt  = MODE_SNAP;
                    w_skip_nxt  = '0;
                    w_state_nxt = ST_ARM;
                end else if (w_video) begin
                    w_mode_nxt  = MODE_VIDEO;
                    w_skip_nxt  = '0;
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vs_fall) begin
                    if (r_skip_cnt == '0) begin
                        w_state_nxt = ST_CAPTURE;
                        w_start_nxt = 1'b1;
                    end else begin
                        w_skip_nxt = r_skip_cnt - SKIP_W'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vs_rise) begin
                    w_done_nxt = 1'b1;
                    if (r_mode == MODE_SNAP) begin
                        w_state_nxt = ST_FROZEN;
                    end else begin
                        w_state_nxt = ST_ARM;
                        w_skip_nxt  = skip_n;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_arm_entry = (w_state_nxt == ST_ARM) && (r_state != ST_ARM);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vs_q        <= 1'b0;
            r_skip_cnt    <= '0;
            r_cap_en      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_vs_q        <= cam.vsync;
            r_skip_cnt    <= w_skip_nxt;
            r_cap_en      <= (w_state_nxt == ST_CAPTURE);
            r_frame_start <= w_start_nxt;
            r_frame_done  <= w_done_nxt;
            if (w_done_nxt)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Pixel count saturates at the buffer depth; further strobes only raise the sticky flag.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_px_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start_nxt) begin
                r_px_cnt <= '0;
            end else if (r_state == ST_CAPTURE && cam.px_wr_in) begin
                if (r_px_cnt < DEPTH)
                    r_px_cnt <= r_px_cnt + AW'(1);
                else
                    r_overflow <= 1'b1;
            end
            if (w_arm_entry)
                r_overflow <= 1'b0;
        end
    end

`ifdef CAM_CTRL_LINE_STATS_EN
    logic        r_href_q, w_href_rise;
    logic [15:0] r_line_cnt, r_lpx_cnt, r_last_lines, r_last_lpx;

    assign w_href_rise = cam.href & ~r_href_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_href_q     <= 1'b0;
            r_line_cnt   <= '0;
            r_lpx_cnt    <= '0;
            r_last_lines <= '0;
            r_last_lpx   <= '0;
        end else begin
            r_href_q <= cam.href;
            if (w_start_nxt) begin
                r_line_cnt <= '0;
                r_lpx_cnt  <= '0;
            end else if (r_cap_en) begin
                if (w_href_rise) begin
                    r_line_cnt <= r_line_cnt + 16'd1;
                    r_lpx_cnt  <= {15'd0, cam.px_wr_in};
                end else if (cam.px_wr_in) begin
                    r_lpx_cnt <= r_lpx_cnt + 16'd1;
                end
            end
            if (w_done_nxt) begin
                r_last_lines <= r_line_cnt;
                r_last_lpx   <= r_lpx_cnt;
            end
        end
    end
`else
    logic w_unused_href;
    assign w_unused_href = cam.href;
`endif

    // Unselected option codes keep whatever was last displayed.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_leds <= '0;
        end else begin
            case (option)
                LED_FRAMES: r_leds <= {8'h00, r_frame_cnt};
                LED_PIXELS: r_leds <= {{(16-AW){1'b0}}, r_px_cnt};
                LED_STATUS: r_leds <= {r_overflow, 5'b0, state_o, r_frame_cnt};
`ifdef CAM_CTRL_LINE_STATS_EN
                LED_LINES:  r_leds <= r_last_lines;
                LED_LPX:    r_leds <= r_last_lpx;
`endif
                default:    r_leds <= r_leds;
            endcase
        end
    end

    assign state_o         = r_state;
    assign frame_cnt       = r_frame_cnt;
    assign overflow        = r_overflow;
    assign leds            = r_leds;
    assign cam.cap_en      = r_cap_en;
    assign cam.frame_start = r_frame_start;
    assign cam.frame_done  = r_frame_done;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: snapshot, decimated video, overflow, stop, reset, priority.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;
    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        btn_snap = 1'b0, btn_video = 1'b0, btn_stop = 1'b0;
    logic [2:0]  skip_n = 3'd0;
    logic [2:0]  option = 3'd0;
    logic [1:0]  state_o;
    logic [7:0]  frame_cnt;
    logic        overflow;
    logic [15:0] leds;

    int n_vec = 0, n_err = 0;
    int n_start = 0, n_done = 0, n_cap = 0;
    int s_start, s_done, s_cap;

    cam_capture_ctrl_if cam();

    cam_capture_ctrl #(.AW(15), .MEM_DEPTH(19200), .SKIP_W(3)) dut (
        .pclk(pclk), .rst(rst), .cam(cam),
        .btn_snap(btn_snap), .btn_video(btn_video), .btn_stop(btn_stop),
        .skip_n(skip_n), .option(option),
        .state_o(state_o), .frame_cnt(frame_cnt), .overflow(overflow), .leds(leds)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (cam.frame_start) n_start++;
        if (cam.frame_done)  n_done++;
        if (cam.cap_en)      n_cap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic press(input logic s, input logic v, input logic p);
        btn_snap = s; btn_video = v; btn_stop = p;
        cyc(4);
        btn_snap = 1'b0; btn_video = 1'b0; btn_stop = 1'b0;
        cyc(2);
    endtask

    task automatic frame_open();
        cam.vsync = 1'b0;
        cyc(2);
    endtask

    task automatic line(input int w);
        cam.href = 1'b1; cam.px_wr_in = 1'b1;
        cyc(w);
        cam.href = 1'b0; cam.px_wr_in = 1'b0;
        cyc(2);
    endtask

    task automatic frame_close();
        cam.vsync = 1'b1;
        cyc(4);
    endtask

    task automatic frame(input int h, input int w);
        frame_open();
        repeat (h) line(w);
        frame_close();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cam.vsync = 1'b1; cam.href = 1'b0; cam.px_wr_in = 1'b0;
        cyc(3);
        chk("rst_state", state_o, 0);
        chk("rst_cap_en", cam.cap_en, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_leds", leds, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        cyc(2);

        // single snapshot: only the first frame is stored
        option = 3'd3;
        press(1, 0, 0);
        chk("snap_arm", state_o, 1);
        s_start = n_start; s_done = n_done;
        frame(120, 160);
        chk("snap_done", n_done - s_done, 1);
        chk("snap_start", n_start - s_start, 1);
        chk("snap_cnt", frame_cnt, 1);
        chk("snap_state", state_o, 3);
        chk("snap_px", leds, 19200);
        s_cap = n_cap; s_done = n_done;
        frame(4, 8);
        frame(4, 8);
        chk("snap_cap_off", n_cap - s_cap, 0);
        chk("snap_no_done", n_done - s_done, 0);
        chk("snap_hold_px", leds, 19200);

        // video with skip_n=2: frames 1,4,7 of 9 stored
        skip_n = 3'd2;
        press(0, 1, 0);
        chk("vid_arm", state_o, 1);
        s_done = n_done;
        for (int i = 0; i < 9; i++) begin
            s_start = n_start;
            frame(2, 4);
            chk($sformatf("vid_start%0d", i + 1), n_start - s_start, (i % 3 == 0) ? 1 : 0);
        end
        chk("vid_done", n_done - s_done, 3);
        chk("vid_cnt", frame_cnt, 4);
        chk("vid_px", leds, 8);
        chk("vid_state", state_o, 1);

        // overflow: one pixel beyond the buffer
        press(0, 0, 1);
        chk("stop_idle", state_o, 0);
        press(1, 0, 0);
        frame_open();
        repeat (120) line(160);
        line(1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_px_sat", leds, 19200);
        frame_close();
        chk("ovf_frozen", state_o, 3);
        option = 3'd7;
        cyc(2);
        chk("ovf_status", leds, 16'h8305);
        press(1, 0, 0);
        chk("ovf_clr", overflow, 0);
        chk("ovf_status_arm", leds, 16'h0105);

        // stop mid-capture at pixel 5000
        option = 3'd3;
        frame_open();
        s_done = n_done;
        repeat (31) line(160);
        line(40);
        btn_stop = 1'b1;
        cyc(2);
        chk("stop_pre_state", state_o, 2);
        chk("stop_pre_cap", cam.cap_en, 1);
        cyc(1);
        chk("stop_state", state_o, 0);
        chk("stop_cap", cam.cap_en, 0);
        btn_stop = 1'b0;
        cyc(2);
        chk("stop_px", leds, 5000);
        frame_close();
        chk("stop_no_done", n_done - s_done, 0);
        chk("stop_cnt", frame_cnt, 5);

        // async reset between clock edges mid-line
        press(1, 0, 0);
        frame_open();
        cam.href = 1'b1; cam.px_wr_in = 1'b1;
        cyc(10);
        chk("ar_cap_pre", cam.cap_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cap", cam.cap_en, 0);
        chk("ar_state", state_o, 0);
        chk("ar_cnt", frame_cnt, 0);
        chk("ar_leds", leds, 0);
        chk("ar_done", cam.frame_done, 0);
        chk("ar_start", cam.frame_start, 0);
        cam.href = 1'b0; cam.px_wr_in = 1'b0;
        cyc(1);
        cam.vsync = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // simultaneous snap+video+stop while frozen: stop wins
        option = 3'd7;
        press(1, 0, 0);
        frame(2, 4);
        chk("pri_frozen", leds, 16'h0301);
        press(1, 1, 1);
        chk("pri_state", state_o, 0);
        chk("pri_leds", leds, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
